// File: rtl/seq_fetch_ctrl_pkg.sv
// Shared types and constants for the Seq program store and fetch controller.
package seq_fetch_ctrl_pkg;

    localparam int SFC_AW = 8;
    localparam int SFC_IW = 12;
    localparam int SFC_CW = 16;

    localparam logic [3:0] SFC_OPC_LIMIT = 4'hA;

    typedef enum logic [2:0] {
        SFC_State_Idle,
        SFC_State_Fetch,
        SFC_State_Issue,
        SFC_State_Halted,
        SFC_State_Error
    } sfc_state_e;

    function automatic logic opc_undef(input logic [3:0] opc);
        return opc > SFC_OPC_LIMIT;
    endfunction

endpackage

// File: rtl/seq_fetch_ctrl_prog_ram.sv
// Single-port program RAM: synchronous write, registered read.
module seq_prog_ram #(
    parameter int AW = 8,
    parameter int IW = 12
) (
    input  logic          clock,
    input  logic [AW-1:0] addr,
    input  logic [IW-1:0] wdata,
    input  logic          wen,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [2**AW];

    always_ff @(posedge clock) begin
        if (wen)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/seq_fetch_ctrl.sv
// Fetch/issue controller for Seq: run, halt, step, breakpoint, retired count.
module seq_fetch_ctrl
    import seq_fetch_ctrl_pkg::*;
#(
    parameter int AW = SFC_AW,
    parameter int IW = SFC_IW,
    parameter int CW = SFC_CW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] seq_next,
    output logic [IW-1:0] inst,
    output logic          inst_en,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic          prog_wen,
    input  logic          cmd_run,
    input  logic          cmd_halt,
    input  logic          cmd_step,
    input  logic [AW-1:0] bp_addr,
    input  logic          bp_en,
    output logic          halted,
    output logic          error,
    output logic          wr_reject,
    output logic [CW-1:0] icount
);

    sfc_state_e    state, state_nx;
    logic          skip_bp, skip_bp_nx;
    logic          step, step_nx;
    logic [IW-1:0] rdata, inst_q;
    logic [AW-1:0] ram_addr;
    logic          host_side, ram_wen, bp_hit, bad_opc, issue;

    // Host owns the RAM port only while the controller is parked.
    assign host_side = (state == SFC_State_Idle) || (state == SFC_State_Halted);
    assign ram_wen   = host_side && prog_wen;
    assign ram_addr  = host_side ? prog_addr : seq_next;

    assign bp_hit  = bp_en && (seq_next == bp_addr) && !skip_bp;
    assign bad_opc = opc_undef(rdata[IW-1 -: 4]);
    assign issue   = (state == SFC_State_Issue) && !bad_opc;

    assign inst_en = issue;
    assign inst    = issue ? rdata : inst_q;
    assign halted  = host_side;
    assign error   = (state == SFC_State_Error);

    seq_prog_ram #(.AW(AW), .IW(IW)) u_ram (
        .clock (clock),
        .addr  (ram_addr),
        .wdata (prog_data),
        .wen   (ram_wen),
        .rdata (rdata)
    );

    always_comb begin
        state_nx   = state;
        skip_bp_nx = skip_bp;
        step_nx    = step;
        unique case (state)
            SFC_State_Idle, SFC_State_Halted: begin
                if (cmd_halt) begin
                    state_nx = state;
                end else if (cmd_step) begin
                    state_nx   = SFC_State_Fetch;
                    skip_bp_nx = 1'b1;
                    step_nx    = 1'b1;
                end else if (cmd_run) begin
                    state_nx   = SFC_State_Fetch;
                    skip_bp_nx = 1'b1;
                    step_nx    = 1'b0;
                end
            end
            SFC_State_Fetch: begin
                if (cmd_halt || bp_hit) begin
                    state_nx = SFC_State_Halted;
                    step_nx  = 1'b0;
                end else begin
                    state_nx = SFC_State_Issue;
                end
            end
            SFC_State_Issue: begin
                if (bad_opc) begin
                    state_nx = SFC_State_Error;
                end else begin
                    skip_bp_nx = 1'b0;
                    // A halt seen here lets this issue retire first.
                    if (step || cmd_halt) begin
                        state_nx = SFC_State_Halted;
                        step_nx  = 1'b0;
                    end else begin
                        state_nx = SFC_State_Fetch;
                    end
                end
            end
            SFC_State_Error: begin
                state_nx = SFC_State_Error;
            end
            default: begin
                state_nx = SFC_State_Idle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= SFC_State_Idle;
            skip_bp   <= 1'b0;
            step      <= 1'b0;
            inst_q    <= '0;
            icount    <= '0;
            wr_reject <= 1'b0;
        end else begin
            state     <= state_nx;
            skip_bp   <= skip_bp_nx;
            step      <= step_nx;
            wr_reject <= prog_wen && !host_side;
            if (issue) begin
                inst_q <= rdata;
                if (icount != '1)
                    icount <= icount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_fetch_ctrl.sv
// Scoreboard bench for seq_fetch_ctrl with a small Seq stand-in.
module tb_seq_fetch_ctrl;

    localparam int AW = 8;
    localparam int IW = 12;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] seq_next;
    logic [IW-1:0] inst;
    logic          inst_en;
    logic [AW-1:0] prog_addr = '0;
    logic [IW-1:0] prog_data = '0;
    logic          prog_wen  = 1'b0;
    logic          cmd_run   = 1'b0;
    logic          cmd_halt  = 1'b0;
    logic          cmd_step  = 1'b0;
    logic [AW-1:0] bp_addr   = '0;
    logic          bp_en     = 1'b0;
    logic          halted;
    logic          error;
    logic          wr_reject;
    logic [CW-1:0] icount;

    typedef struct packed {
        logic [IW-1:0] inst;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          exp_q[$];
    logic [CW-1:0] exp_cnt = '0;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clock = ~clock;

    seq_fetch_ctrl #(.AW(AW), .IW(IW), .CW(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .seq_next  (seq_next),
        .inst      (inst),
        .inst_en   (inst_en),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_wen  (prog_wen),
        .cmd_run   (cmd_run),
        .cmd_halt  (cmd_halt),
        .cmd_step  (cmd_step),
        .bp_addr   (bp_addr),
        .bp_en     (bp_en),
        .halted    (halted),
        .error     (error),
        .wr_reject (wr_reject),
        .icount    (icount)
    );

    // Seq stand-in: opcode 7 jumps to 0, everything else advances.
    always @(posedge clock or negedge reset) begin
        if (!reset)
            seq_next <= '0;
        else if (inst_en)
            seq_next <= (inst[11:8] == 4'h7) ? '0 : seq_next + 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Expected icount is the value shown while the issue is on the bus.
    task automatic expect_issue(input logic [IW-1:0] v);
        exp_q.push_back('{inst: v, cnt: exp_cnt});
        if (exp_cnt != '1)
            exp_cnt++;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset && inst_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_issue: got inst %0h required none", inst);
            end else begin
                e = exp_q.pop_front();
                check("issue_inst", 32'(inst), 32'(e.inst));
                check("issue_icount", 32'(icount), 32'(e.cnt));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_cnt = '0;
        ticks(2);
        reset = 1'b1;
        tick();
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
        prog_addr = a;
        prog_data = d;
        prog_wen  = 1'b1;
        tick();
        prog_wen  = 1'b0;
    endtask

    task automatic pulse_run();
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
    endtask

    task automatic pulse_step();
        cmd_step = 1'b1;
        tick();
        cmd_step = 1'b0;
    endtask

    task automatic pulse_halt();
        cmd_halt = 1'b1;
        tick();
        cmd_halt = 1'b0;
    endtask

    task automatic wait_halted(input string name, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(halted), 32'd1);
    endtask

    task automatic wait_error(input string name, input int budget);
        int n;
        n = 0;
        while (!error && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(error), 32'd1);
    endtask

    initial begin
        logic [IW-1:0] pat [3];
        int n;
        pat[0] = 12'h105;
        pat[1] = 12'h321;
        pat[2] = 12'h700;

        // reset values
        ticks(2);
        check("rst_inst_en", 32'(inst_en), 32'd0);
        check("rst_inst", 32'(inst), 32'd0);
        check("rst_halted", 32'(halted), 32'd1);
        check("rst_error", 32'(error), 32'd0);
        check("rst_wr_reject", 32'(wr_reject), 32'd0);
        check("rst_icount", 32'(icount), 32'd0);
        reset = 1'b1;
        tick();

        // 1: load and run, 4 issues then halt
        load(0, 12'h105);
        check("idle_write_no_reject", 32'(wr_reject), 32'd0);
        load(1, 12'h321);
        load(2, 12'h700);
        expect_issue(12'h105);
        expect_issue(12'h321);
        expect_issue(12'h700);
        expect_issue(12'h105);
        pulse_run();
        check("lat_cycle1", 32'(inst_en), 32'd0);
        tick();
        check("lat_cycle2", 32'(inst_en), 32'd1);
        ticks(6);
        pulse_halt();
        check("run_halted", 32'(halted), 32'd1);
        check("run_icount", 32'(icount), 32'd4);
        check("run_next", 32'(seq_next), 32'd1);

        // 2: breakpoint at 2, then resume past it
        do_reset();
        bp_en = 1'b1;
        bp_addr = 8'd2;
        expect_issue(12'h105);
        expect_issue(12'h321);
        pulse_run();
        wait_halted("bp_halt", 20);
        check("bp_next", 32'(seq_next), 32'd2);
        check("bp_icount", 32'(icount), 32'd2);
        expect_issue(12'h700);
        expect_issue(12'h105);
        expect_issue(12'h321);
        pulse_run();
        wait_halted("bp_rehalt", 20);
        check("bp_resume_icount", 32'(icount), 32'd5);

        // 3: three single steps
        for (int k = 0; k < 3; k++) begin
            expect_issue(pat[(k + 2) % 3]);
            pulse_step();
            check("step_busy", 32'(halted), 32'd0);
            wait_halted("step_halt", 10);
            check("step_icount", 32'(icount), 32'(6 + k));
        end
        check("step_next", 32'(seq_next), 32'd2);

        // 6: run and halt together while halted
        cmd_run = 1'b1;
        cmd_halt = 1'b1;
        tick();
        cmd_run = 1'b0;
        cmd_halt = 1'b0;
        ticks(4);
        check("run_halt_same", 32'(halted), 32'd1);
        check("run_halt_icount", 32'(icount), 32'd8);

        // 5: write while running is rejected
        bp_en = 1'b0;
        expect_issue(12'h700);
        expect_issue(12'h105);
        pulse_run();
        prog_addr = 8'd0;
        prog_data = 12'h999;
        prog_wen  = 1'b1;
        tick();
        prog_wen  = 1'b0;
        check("wr_reject_pulse", 32'(wr_reject), 32'd1);
        tick();
        check("wr_reject_end", 32'(wr_reject), 32'd0);
        tick();
        pulse_halt();
        check("wr_halted", 32'(halted), 32'd1);
        check("wr_icount", 32'(icount), 32'd10);

        // 4: undefined opcode drives Error
        do_reset();
        load(1, 12'hF00);
        expect_issue(12'h105);
        pulse_run();
        wait_error("err_enter", 20);
        check("err_halted", 32'(halted), 32'd0);
        check("err_icount", 32'(icount), 32'd1);
        check("err_inst_hold", 32'(inst), 32'h105);
        check("err_inst_en", 32'(inst_en), 32'd0);
        pulse_run();
        ticks(3);
        check("err_sticky", 32'(error), 32'd1);
        load(0, 12'h123);
        check("err_wr_reject", 32'(wr_reject), 32'd1);

        // 7: reset during Issue
        do_reset();
        check("err_cleared", 32'(error), 32'd0);
        load(1, 12'h321);
        expect_issue(12'h105);
        pulse_run();
        ticks(3);
        check("pre_rst_issue", 32'(inst_en), 32'd1);
        check("pre_rst_icount", 32'(icount), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_inst_en", 32'(inst_en), 32'd0);
        check("rst_mid_icount", 32'(icount), 32'd0);
        exp_cnt = '0;
        tick();
        reset = 1'b1;
        tick();

        // opcode boundary: A is legal, B is not
        load(1, 12'hA55);
        load(2, 12'hB00);
        expect_issue(12'h105);
        expect_issue(12'hA55);
        pulse_run();
        wait_error("opc_b_error", 20);
        check("opc_a_icount", 32'(icount), 32'd2);
        check("opc_a_inst", 32'(inst), 32'hA55);

        // icount saturation
        do_reset();
        load(1, 12'h321);
        load(2, 12'h700);
        for (int i = 0; i < 18; i++)
            expect_issue(pat[i % 3]);
        pulse_run();
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            tick();
            n++;
        end
        check("sat_drain", 32'(exp_q.size()), 32'd0);
        pulse_halt();
        check("sat_halted", 32'(halted), 32'd1);
        check("sat_icount", 32'(icount), 32'hF);

        ticks(2);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

endmodule
